// File: rtl/data_mem_arbiter_if.sv
// Shared types and the requester/memory bundle for the two-port data memory arbiter.
package data_mem_arbiter_pkg;
  typedef enum logic [2:0] {
    BYTE_S = 3'd0,
    HALF_S = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd4,
    HALF_U = 3'd5
  } data_size_e;
endpackage

interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import data_mem_arbiter_pkg::*;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_we;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  data_size_e [1:0]           req_unit;
  logic [1:0][31:0]           req_wdata;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_err;
  logic [31:0]                rsp_rdata;

  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic                       mem_re;
  logic                       mem_we;
  data_size_e                 mem_unit;
  logic [31:0]                mem_wdata;
  logic [31:0]                mem_rdata;

  logic                       busy;

  // Arbiter side: takes requests and memory read data, drives everything else
  modport slave (
    input  req_valid, req_we, req_addr, req_unit, req_wdata, mem_rdata,
    output req_ready, req_err, rsp_rdata,
    output mem_addr, mem_re, mem_we, mem_unit, mem_wdata, busy
  );

  // Environment side: requesters plus the memory itself
  modport master (
    output req_valid, req_we, req_addr, req_unit, req_wdata, mem_rdata,
    input  req_ready, req_err, rsp_rdata,
    input  mem_addr, mem_re, mem_we, mem_unit, mem_wdata, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-ported data memory,
// with configurable wait states, misalignment rejection and store unit normalisation.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state, state_d;
  logic                  grant, grant_d;
  logic                  last_grant, last_grant_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_d;
  logic                  lat_we, lat_we_d;
  data_size_e            lat_unit, lat_unit_d;
  logic [31:0]           lat_wdata, lat_wdata_d;

  logic [1:0]            ready_q, ready_d;
  logic [1:0]            err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  data_size_e            unit_q, unit_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;

  logic                  sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  data_size_e            sel_unit;
  logic [31:0]           sel_wdata;
  logic                  sel_mis;

  // Signed store units make no sense to the memory; collapse them to the unsigned form
  function automatic data_size_e norm_unit(input logic we, input data_size_e u);
    data_size_e r;
    r = u;
    if (we && (u == BYTE_S)) r = BYTE_U;
    if (we && (u == HALF_S)) r = HALF_U;
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input data_size_e u);
    logic r;
    case (u)
      HALF_S, HALF_U: r = a[0];
      WORD:           r = (a != 2'b00);
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  // Pick the port to grant: a lone requester wins, a tie goes opposite the last grant
  always_comb begin : req_select
    sel = 1'b0;
    case (bus.req_valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
    sel_addr  = bus.req_addr[sel];
    sel_we    = bus.req_we[sel];
    sel_unit  = norm_unit(sel_we, bus.req_unit[sel]);
    sel_wdata = bus.req_wdata[sel];
    sel_mis   = misaligned(sel_addr[1:0], sel_unit);
  end

  // Next state; registered outputs are precomputed for the state being entered
  always_comb begin : fsm_next
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    lat_addr_d   = lat_addr;
    lat_we_d     = lat_we;
    lat_unit_d   = lat_unit;
    lat_wdata_d  = lat_wdata;
    ready_d      = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    addr_d       = '0;
    re_d         = 1'b0;
    we_d         = 1'b0;
    unit_d       = BYTE_S;
    wdata_d      = 32'h0;

    case (state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          grant_d      = sel;
          last_grant_d = sel;
          lat_addr_d   = sel_addr;
          lat_we_d     = sel_we;
          lat_unit_d   = sel_unit;
          lat_wdata_d  = sel_wdata;
          cnt_d        = CNT_W'(WAIT_STATES);
          if (sel_mis) begin
            state_d      = S_DONE;
            ready_d[sel] = 1'b1;
            err_d[sel]   = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            state_d = S_ACCESS;
            addr_d  = sel_addr;
            unit_d  = sel_unit;
            re_d    = ~sel_we;
            we_d    = sel_we && (WAIT_STATES == 32'd0);
            wdata_d = sel_we ? sel_wdata : 32'h0;
          end
        end
      end

      S_ACCESS: begin
        if (cnt == '0) begin
          state_d        = S_DONE;
          ready_d[grant] = 1'b1;
          rdata_d        = lat_we ? 32'h0 : bus.mem_rdata;
        end else begin
          // Still accessing next cycle; the write strobe lands only on the last one
          cnt_d   = cnt - CNT_W'(1);
          addr_d  = lat_addr;
          unit_d  = lat_unit;
          re_d    = ~lat_we;
          we_d    = lat_we && (cnt == CNT_W'(1));
          wdata_d = lat_we ? lat_wdata : 32'h0;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_unit   <= BYTE_S;
      lat_wdata  <= 32'h0;
      ready_q    <= 2'b00;
      err_q      <= 2'b00;
      rdata_q    <= 32'h0;
      addr_q     <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      unit_q     <= BYTE_S;
      wdata_q    <= 32'h0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      lat_addr   <= lat_addr_d;
      lat_we     <= lat_we_d;
      lat_unit   <= lat_unit_d;
      lat_wdata  <= lat_wdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      we_q       <= we_d;
      unit_q     <= unit_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_unit  = unit_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: one instance with no wait states, one with three,
// each backed by a byte-array memory, checked against a transaction-level model.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW)) b0 ();
  data_mem_arbiter_if #(.ADDR_WIDTH(AW)) b3 ();

  data_mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  data_mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // Requester drive; sel routes the request to one instance at a time
  bit                 sel = 1'b0;
  logic [1:0]         valid_v = 2'b00;
  logic [1:0]         we_v = 2'b00;
  logic [1:0][AW-1:0] addr_v = '0;
  data_size_e [1:0]   unit_v;
  logic [1:0][31:0]   wdata_v = '0;

  assign b0.req_valid = sel ? 2'b00 : valid_v;
  assign b3.req_valid = sel ? valid_v : 2'b00;
  assign b0.req_we    = we_v;
  assign b3.req_we    = we_v;
  assign b0.req_addr  = addr_v;
  assign b3.req_addr  = addr_v;
  assign b0.req_unit  = unit_v;
  assign b3.req_unit  = unit_v;
  assign b0.req_wdata = wdata_v;
  assign b3.req_wdata = wdata_v;

  logic [1:0]  v_ready, v_err;
  logic [31:0] v_rdata;
  assign v_ready = sel ? b3.req_ready : b0.req_ready;
  assign v_err   = sel ? b3.req_err : b0.req_err;
  assign v_rdata = sel ? b3.rsp_rdata : b0.rsp_rdata;

  function automatic logic [31:0] ext(input logic [31:0] w, input data_size_e u);
    case (u)
      BYTE_S:  return {{24{w[7]}}, w[7:0]};
      BYTE_U:  return {24'h0, w[7:0]};
      HALF_S:  return {{16{w[15]}}, w[15:0]};
      HALF_U:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(input data_size_e u);
    case (u)
      BYTE_S, BYTE_U: return 1;
      HALF_S, HALF_U: return 2;
      default:        return 4;
    endcase
  endfunction

  // Memory behind each instance: asynchronous extending read, unit-sized write on the edge
  logic [7:0] mem [2][256] = '{default: 8'h00};

  assign b0.mem_rdata = ext({mem[0][8'(b0.mem_addr + 8'd3)], mem[0][8'(b0.mem_addr + 8'd2)],
                             mem[0][8'(b0.mem_addr + 8'd1)], mem[0][b0.mem_addr]}, b0.mem_unit);
  assign b3.mem_rdata = ext({mem[1][8'(b3.mem_addr + 8'd3)], mem[1][8'(b3.mem_addr + 8'd2)],
                             mem[1][8'(b3.mem_addr + 8'd1)], mem[1][b3.mem_addr]}, b3.mem_unit);

  always @(posedge clk) begin
    if (b0.mem_we)
      for (int i = 0; i < nbytes(b0.mem_unit); i++)
        mem[0][8'(b0.mem_addr + 8'(i))] <= b0.mem_wdata[8*i +: 8];
    if (b3.mem_we)
      for (int i = 0; i < nbytes(b3.mem_unit); i++)
        mem[1][8'(b3.mem_addr + 8'(i))] <= b3.mem_wdata[8*i +: 8];
  end

  // Activity monitors sampled mid-cycle
  int         re_cnt [2] = '{0, 0};
  int         we_cnt [2] = '{0, 0};
  int         rdy_cnt[2] = '{0, 0};
  int         both_rdy = 0;
  data_size_e w_unit [2];
  logic [7:0] w_addr [2];
  logic [31:0] w_data[2];

  always @(negedge clk) begin
    if (b0.mem_re) re_cnt[0] <= re_cnt[0] + 1;
    if (b3.mem_re) re_cnt[1] <= re_cnt[1] + 1;
    if (b0.mem_we) begin
      we_cnt[0] <= we_cnt[0] + 1; w_unit[0] <= b0.mem_unit;
      w_addr[0] <= b0.mem_addr; w_data[0] <= b0.mem_wdata;
    end
    if (b3.mem_we) begin
      we_cnt[1] <= we_cnt[1] + 1; w_unit[1] <= b3.mem_unit;
      w_addr[1] <= b3.mem_addr; w_data[1] <= b3.mem_wdata;
    end
    rdy_cnt[0] <= rdy_cnt[0] + 32'(b0.req_ready[0]) + 32'(b0.req_ready[1]);
    rdy_cnt[1] <= rdy_cnt[1] + 32'(b3.req_ready[0]) + 32'(b3.req_ready[1]);
    if ((&b0.req_ready) || (&b3.req_ready)) both_rdy <= both_rdy + 1;
  end

  // Reference model: byte image of each memory as the architecture should leave it
  logic [7:0] mm [2][256] = '{default: 8'h00};

  function automatic bit mis(input logic [7:0] a, input data_size_e u);
    if ((u == HALF_S || u == HALF_U) && a[0]) return 1'b1;
    if (u == WORD && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input bit s, input logic [7:0] a, input data_size_e u);
    return ext({mm[s][8'(a + 8'd3)], mm[s][8'(a + 8'd2)], mm[s][8'(a + 8'd1)], mm[s][a]}, u);
  endfunction

  task automatic model_apply(input bit s, input bit we, input logic [7:0] a,
                             input data_size_e u, input logic [31:0] wd);
    if (we && !mis(a, u))
      for (int i = 0; i < nbytes(u); i++) mm[s][8'(a + 8'(i))] = wd[8*i +: 8];
  endtask

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (v_ready == 2'b00 && n < 40);
    if (v_ready == 2'b00) begin
      nchk++; nerr++;
      $display("FAIL ready_timeout: got no ready after %0d cycles", n);
    end
  endtask

  // One request on one port; lat counts cycles from the IDLE cycle that sees it
  task automatic run_txn(input bit s, input bit p, input bit we, input logic [7:0] a,
                         input data_size_e u, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output int rec, output int wec, output logic [1:0] rdy);
    int r0, w0;
    @(posedge clk); #1;
    sel = s; we_v[p] = we; addr_v[p] = a; unit_v[p] = u; wdata_v[p] = wd;
    valid_v = 2'b00; valid_v[p] = 1'b1;
    r0 = re_cnt[s]; w0 = we_cnt[s];
    @(negedge clk);
    wait_ready(lat);
    err = v_err[p]; rdata = v_rdata; rdy = v_ready;
    @(posedge clk); #1;
    valid_v = 2'b00;
    rec = re_cnt[s] - r0; wec = we_cnt[s] - w0;
    model_apply(s, we, a, u, wd);
  endtask

  typedef struct {
    bit         s;
    bit         p;
    bit         we;
    logic [7:0] a;
    data_size_e u;
    logic [31:0] wd;
    bit         e_err;
    logic [31:0] e_rd;
    int         e_lat;
    int         e_re;
    int         e_we;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit p, input bit we, input logic [7:0] a,
                              input data_size_e u, input logic [31:0] wd, input bit e_err,
                              input logic [31:0] e_rd, input int e_lat, input int e_re,
                              input int e_we);
    vec_t v;
    v.s = s; v.p = p; v.we = we; v.a = a; v.u = u; v.wd = wd;
    v.e_err = e_err; v.e_rd = e_rd; v.e_lat = e_lat; v.e_re = e_re; v.e_we = e_we;
    return v;
  endfunction

  vec_t       vt[12];
  data_size_e ulist[5] = '{BYTE_S, BYTE_U, HALF_S, HALF_U, WORD};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rec, wec, n, w0, r0;
    logic err;
    logic [31:0] rd, e_rd;
    logic [1:0] rdy;
    bit lg, ep, s, p, we, m;
    data_size_e u;
    logic [7:0] a;
    logic [31:0] wd;

    unit_v[0] = BYTE_S;
    unit_v[1] = BYTE_S;

    //            dut port we  addr   unit    wdata         err rdata         lat re we
    vt[0]  = mk(0, 0, 1, 8'h08, WORD,   32'hDEADBEEF, 0, 32'h00000000, 2, 0, 1);
    vt[1]  = mk(0, 0, 0, 8'h08, WORD,   32'h0,        0, 32'hDEADBEEF, 2, 1, 0);
    vt[2]  = mk(1, 1, 1, 8'h02, HALF_U, 32'h00008001, 0, 32'h00000000, 5, 0, 1);
    vt[3]  = mk(1, 1, 0, 8'h02, HALF_S, 32'h0,        0, 32'hFFFF8001, 5, 4, 0);
    vt[4]  = mk(0, 0, 0, 8'h06, WORD,   32'h0,        1, 32'h00000000, 1, 0, 0);
    vt[5]  = mk(0, 1, 0, 8'h03, HALF_U, 32'h0,        1, 32'h00000000, 1, 0, 0);
    vt[6]  = mk(1, 0, 1, 8'h01, WORD,   32'hAAAA5555, 1, 32'h00000000, 1, 0, 0);
    vt[7]  = mk(0, 1, 1, 8'h05, BYTE_S, 32'h000001FF, 0, 32'h00000000, 2, 0, 1);
    vt[8]  = mk(0, 0, 0, 8'h05, BYTE_U, 32'h0,        0, 32'h000000FF, 2, 1, 0);
    vt[9]  = mk(0, 0, 0, 8'h05, BYTE_S, 32'h0,        0, 32'hFFFFFFFF, 2, 1, 0);
    vt[10] = mk(0, 1, 0, 8'h04, HALF_U, 32'h0,        0, 32'h0000FF00, 2, 1, 0);
    vt[11] = mk(1, 0, 0, 8'h00, WORD,   32'h0,        0, 32'h80010000, 5, 4, 0);

    // Reset state of both instances
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl0", 32'({b0.req_ready, b0.req_err, b0.busy, b0.mem_re, b0.mem_we}), 32'h0);
    chk("rst_mem0", 32'({b0.mem_addr, b0.mem_unit}), 32'h0);
    chk("rst_data0", b0.rsp_rdata | b0.mem_wdata, 32'h0);
    chk("rst_ctl3", 32'({b3.req_ready, b3.req_err, b3.busy, b3.mem_re, b3.mem_we}), 32'h0);
    chk("rst_data3", b3.rsp_rdata | b3.mem_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_txn(vt[i].s, vt[i].p, vt[i].we, vt[i].a, vt[i].u, vt[i].wd, lat, err, rd, rec, wec, rdy);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_rdata", i), rd, vt[i].e_rd);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
      chk($sformatf("v%0d_re_cycles", i), 32'(rec), 32'(vt[i].e_re));
      chk($sformatf("v%0d_we_cycles", i), 32'(wec), 32'(vt[i].e_we));
      chk($sformatf("v%0d_ready_port", i), 32'(rdy), vt[i].p ? 32'd2 : 32'd1);
      if (vt[i].e_we == 1) begin
        chk($sformatf("v%0d_waddr", i), 32'(w_addr[vt[i].s]), 32'(vt[i].a));
        chk($sformatf("v%0d_wdata", i), w_data[vt[i].s], vt[i].wd);
      end
      if (i == 7) begin
        chk("bytes_wunit", 32'(w_unit[0]), 32'(BYTE_U));
        chk("bytes_mem5", 32'(mem[0][5]), 32'h000000FF);
        chk("bytes_mem6", 32'(mem[0][6]), 32'h00000000);
      end
    end

    // Contention: both ports held valid for four grants after a fresh reset
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    sel = 1'b0; we_v = 2'b00;
    addr_v[0] = 8'h08; unit_v[0] = WORD;
    addr_v[1] = 8'h04; unit_v[1] = HALF_U;
    r0 = rdy_cnt[0];
    valid_v = 2'b11;
    lg = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_ready(n);
      ep = !lg;
      chk($sformatf("cont%0d_grant", k), 32'(v_ready), ep ? 32'd2 : 32'd1);
      chk($sformatf("cont%0d_rdata", k), v_rdata,
          model_read(1'b0, ep ? 8'h04 : 8'h08, ep ? HALF_U : WORD));
      chk($sformatf("cont%0d_gap", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
      lg = ep;
    end
    @(posedge clk); #1 valid_v = 2'b00;
    repeat (4) @(posedge clk);
    chk("cont_ready_pulses", 32'(rdy_cnt[0] - r0), 32'd4);

    // Randomised traffic against the model
    for (int k = 0; k < 40; k++) begin
      s  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      u  = ulist[$urandom_range(0, 4)];
      a  = 8'($urandom_range(0, 31));
      wd = $urandom;
      m  = mis(a, u);
      e_rd = (we || m) ? 32'h0 : model_read(s, a, u);
      run_txn(s, p, we, a, u, wd, lat, err, rd, rec, wec, rdy);
      chk($sformatf("r%0d_err", k), 32'(err), 32'(m));
      chk($sformatf("r%0d_rdata", k), rd, e_rd);
      chk($sformatf("r%0d_lat", k), 32'(lat), m ? 32'd1 : (s ? 32'd5 : 32'd2));
      chk($sformatf("r%0d_re_cycles", k), 32'(rec), (!we && !m) ? (s ? 32'd4 : 32'd1) : 32'd0);
      chk($sformatf("r%0d_we_cycles", k), 32'(wec), (we && !m) ? 32'd1 : 32'd0);
    end

    // Reset during the second ACCESS cycle of a store on the wait-state instance
    @(posedge clk); #1;
    sel = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h20; unit_v[0] = WORD; wdata_v[0] = 32'h12345678;
    valid_v = 2'b01;
    w0 = we_cnt[1]; r0 = rdy_cnt[1];
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(b3.busy), 32'd1);
    chk("abort_we_pre", 32'(b3.mem_we), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_ctl", 32'({b3.req_ready, b3.req_err, b3.busy, b3.mem_re, b3.mem_we}), 32'h0);
    chk("abort_mem", 32'({b3.mem_addr, b3.mem_unit}), 32'h0);
    chk("abort_data", b3.rsp_rdata | b3.mem_wdata, 32'h0);
    valid_v = 2'b00;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("abort_no_write", 32'(we_cnt[1] - w0), 32'd0);
    chk("abort_no_ready", 32'(rdy_cnt[1] - r0), 32'd0);
    chk("abort_mem_word", {mem[1][8'h23], mem[1][8'h22], mem[1][8'h21], mem[1][8'h20]},
        model_read(1'b1, 8'h20, WORD));

    // First tie after reset goes to port 0, then port 1 is served
    @(posedge clk); #1;
    we_v = 2'b00;
    addr_v[0] = 8'h20; unit_v[0] = WORD;
    addr_v[1] = 8'h00; unit_v[1] = WORD;
    valid_v = 2'b11;
    @(negedge clk);
    wait_ready(n);
    chk("tie_grant0", 32'(v_ready), 32'd1);
    chk("tie_lat0", 32'(n), 32'd5);
    chk("tie_rdata0", v_rdata, model_read(1'b1, 8'h20, WORD));
    @(posedge clk); #1 valid_v[0] = 1'b0;
    wait_ready(n);
    chk("tie_grant1", 32'(v_ready), 32'd2);
    chk("tie_lat1", 32'(n), 32'd6);
    chk("tie_rdata1", v_rdata, model_read(1'b1, 8'h00, WORD));
    @(posedge clk); #1 valid_v = 2'b00;
    repeat (3) @(posedge clk);

    chk("never_both_ready", 32'(both_rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the single-ported `data_memory`. It shares the memory between the core load/store unit (port 0) and a secondary requester such as a test loader or future DMA (port 1), granting round-robin. It models a configurable number of wait states, so the core can be exercised against slower memory before the cache system lands. It also rejects misaligned accesses and normalises store access units before they reach the memory.

## Interface
- `WAIT_STATES`, default 0: extra ACCESS cycles per transaction, 0..15.
- `clk`  in  1  system clock, all state on posedge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid_i`  in  [1:0]  per-port request; held stable until that port's `req_ready_o`.
- `req_we_i`  in  [1:0]  1 = store, 0 = load.
- `req_addr_i`  in  [1:0][ADDR_WIDTH-1:0]  byte address.
- `req_unit_i`  in  [1:0] data_size_e  access unit.
- `req_wdata_i`  in  [1:0][31:0]  store data, right-aligned.
- `req_ready_o`  out  [1:0]  one-cycle completion pulse.
- `req_err_o`  out  [1:0]  misalignment flag, valid with `req_ready_o`.
- `rsp_rdata_o`  out  32  registered load data, valid with `req_ready_o`.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_re_o`  out  1  memory read enable.
- `mem_we_o`  out  1  memory write enable.
- `mem_unit_o`  out  data_size_e  memory access unit.
- `mem_wdata_o`  out  32  store data; the top level drives the shared bus from it when `mem_we_o`=1.
- `mem_rdata_i`  in  32  memory read data.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any `req_valid_i` is set, grant one port.
    - If only one port is valid, grant it.
    - If both are valid, grant the port opposite `last_grant`.
  - On a grant, latch the granted port's address, write enable, unit and write data, and set `last_grant`.
  - Load `cnt` with `WAIT_STATES`.
  - Go to ACCESS, or straight to DONE with error set if the access is misaligned.
- Misaligned: HALF_S/HALF_U with `addr[0]`=1, or WORD with `addr[1:0]`≠0. No memory enable is asserted, `rsp_rdata_o` is 0 and `req_err_o` is 1.
- ACCESS:
  - `mem_addr_o` and `mem_unit_o` come from the latched values.
  - For loads, `mem_re_o`=1 in every ACCESS cycle.
  - For stores, `mem_we_o`=1 only in the final ACCESS cycle (`cnt`==0), giving exactly one write edge per store.
  - `cnt` decrements each cycle.
  - When `cnt`==0:
    - Loads capture `mem_rdata_i` into `rsp_rdata_o`.
    - Stores clear `rsp_rdata_o` to 0.
    - Go to DONE.
- Store unit normalisation: BYTE_S→BYTE_U and HALF_S→HALF_U on `mem_unit_o`. Loads pass the unit unchanged.
- DONE:
  - `req_ready_o[grant]`=1 and `req_err_o[grant]`=error flag.
  - Next state is IDLE unconditionally.
  - A still-asserted valid in IDLE is treated as a new request.
- Outside ACCESS: `mem_re_o`=`mem_we_o`=0, `mem_addr_o`=0 and `mem_wdata_o`=0.

## Timing
- Reset values:
  - state IDLE, `last_grant`=1 (so port 0 wins the first tie), `cnt`=0.
  - `rsp_rdata_o`=0, `req_ready_o`=0, `req_err_o`=0, `busy_o`=0.
  - All memory outputs 0.
- Latency with request seen in IDLE at cycle t:
  - ACCESS occupies cycles t+1 .. t+1+`WAIT_STATES`.
  - `req_ready_o` is high at cycle t+2+`WAIT_STATES`.
- Misaligned latency: ready at t+1.
- Back-to-back throughput: one transaction per `WAIT_STATES`+3 cycles.
- Contention: with both ports valid continuously, grants alternate 0,1,0,1,…
- A port's valid dropping mid-transaction does not abort it; the latched access completes and still pulses ready.
- Reset asserted mid-ACCESS:
  - immediate return to IDLE with all outputs at reset values.
  - no write pulse is produced, and no ready is issued for the aborted transaction.
- `req_ready_o` is never high on both ports in the same cycle.

## Test plan
- `WAIT_STATES`=0, port 0 WORD store 0xDEADBEEF @0x8, then WORD load @0x8:
  - store: ready 2 cycles after request, exactly one `mem_we_o` cycle.
  - load: `rsp_rdata_o`=0xDEADBEEF with ready 2 cycles after request, `req_err_o`=0.
- `WAIT_STATES`=3, port 1 HALF_S load @0x2 of 0x8001:
  - `mem_re_o` high for 4 cycles.
  - ready at t+5 with `rsp_rdata_o`=0xFFFF8001.
- Both ports valid continuously for 4 transactions:
  - grant order 0,1,0,1.
  - no cycle has both ready bits set.
- Misaligned requests, WORD @0x6 and HALF_U @0x3:
  - ready at t+1 with `req_err_o`=1 and `rsp_rdata_o`=0.
  - `mem_re_o`/`mem_we_o` never asserted.
- Store with BYTE_S @0x5 data 0x1FF:
  - `mem_unit_o`=BYTE_U during the write cycle.
  - the memory byte at 0x5 becomes 0xFF.
- `WAIT_STATES`=3, reset asserted during the second ACCESS cycle of a store:
  - all outputs return to reset values, no `mem_we_o` pulse, no ready.
  - after reset release, port 0 wins the first tie.
